// File: rtl/serial_add_ctrl_if.sv
// Operand request / result response bundle for the bit-serial adder controller.
interface serial_add_ctrl_if #(
  parameter int unsigned N = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         co;
  logic         busy;

  // Requester / result consumer side
  modport master (
    output in_valid, a, b, ci, out_ready,
    input  in_ready, out_valid, sum, co, busy
  );

  // Adder controller side
  modport slave (
    input  in_valid, a, b, ci, out_ready,
    output in_ready, out_valid, sum, co, busy
  );

endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: one full-adder slice stepped LSB first, one bit per clock,
// with valid/ready handshakes on operands and on the {co,sum} result.
module serial_add_ctrl #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             rstN,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [N-1:0]    a_sr;
  logic [N-1:0]    a_sr_n;
  logic [N-1:0]    b_sr;
  logic [N-1:0]    b_sr_n;
  logic [N-1:0]    sum_sr;
  logic [N-1:0]    sum_sr_n;
  logic            carry;
  logic            carry_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic            s_bit;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      a_sr   <= a_sr_n;
      b_sr   <= b_sr_n;
      sum_sr <= sum_sr_n;
      carry  <= carry_n;
      cnt    <= cnt_n;
    end
  end

  // Next-state and datapath update: load on accept, one full-adder step per RUN cycle
  always_comb begin
    state_n  = state;
    a_sr_n   = a_sr;
    b_sr_n   = b_sr;
    sum_sr_n = sum_sr;
    carry_n  = carry;
    cnt_n    = cnt;
    s_bit    = a_sr[0] ^ b_sr[0] ^ carry;

    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sr_n  = bus.a;
          b_sr_n  = bus.b;
          carry_n = bus.ci;
          cnt_n   = '0;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        carry_n  = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
        // New sum bit enters at the MSB so the LSB-first stream lands in place after N steps
        sum_sr_n = (sum_sr >> 1) | (N'(s_bit) << (N - 1));
        a_sr_n   = a_sr >> 1;
        b_sr_n   = b_sr >> 1;
        cnt_n    = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Handshake and result outputs decoded from registered state only
  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.sum       = sum_sr;
  assign bus.co        = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against an arithmetic a+b+ci reference.
module tb_serial_add_ctrl;

  localparam int unsigned N = 8;

  logic clk;
  logic rstN;
  int   n_cmp;
  int   n_err;

  serial_add_ctrl_if #(.N(N)) bus ();

  serial_add_ctrl #(.N(N)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic ci);
    int unsigned r;
    r = int'(a) + int'(b) + int'(ci);
    return 32'(r);
  endfunction

  function automatic logic [31:0] dut_result();
    return 32'({bus.co, bus.sum});
  endfunction

  // Present an operand set at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic ci);
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.in_valid = 1'b1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Count edges from the accept until out_valid, bounded
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 4 * N + 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reset(input int cycles);
    rstN = 1'b0;
    repeat (cycles) @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    int          lat;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic        rc;
    logic        seen;
    n_cmp         = 0;
    n_err         = 0;
    rstN          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.ci        = 1'b0;

    // 1: reset values, then FF+01 with latency check
    @(negedge clk);
    do_reset(2);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_co",        32'(bus.co),        32'd0);
    issue("t1", 8'hFF, 8'h01, 1'b0);
    check("t1_busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check("t1_latency", 32'(lat), 32'(N));
    check("t1_result", dut_result(), ref_add(8'hFF, 8'h01, 1'b0));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // 2: out_valid lasts one cycle when the consumer is ready
    bus.out_ready = 1'b1;
    issue("t2", 8'h5A, 8'hA5, 1'b1);
    wait_done(lat);
    check("t2_latency", 32'(lat), 32'(N));
    check("t2_result", dut_result(), ref_add(8'h5A, 8'hA5, 1'b1));
    @(negedge clk);
    check("t2_valid_drop", 32'(bus.out_valid), 32'd0);
    check("t2_ready_back", 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b0;

    // 3: backpressure in DONE while a new request waits
    issue("t3", 8'h03, 8'h04, 1'b0);
    wait_done(lat);
    check("t3_latency", 32'(lat), 32'(N));
    bus.a        = 8'hFF;
    bus.b        = 8'h04;
    bus.ci       = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_result", dut_result(), ref_add(8'h03, 8'h04, 1'b0));
      check("t3_hold_valid",  32'(bus.out_valid), 32'd1);
      check("t3_hold_nready", 32'(bus.in_ready),  32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t3_idle_valid", 32'(bus.out_valid), 32'd0);
    check("t3_idle_ready", 32'(bus.in_ready),  32'd1);
    check("t3_idle_keep",  dut_result(), ref_add(8'h03, 8'h04, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("t3_second_busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check("t3_second_lat", 32'(lat), 32'(N));
    check("t3_second_result", dut_result(), ref_add(8'hFF, 8'h04, 1'b0));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // 4: reset mid-RUN discards the operation
    issue("t4", 8'h80, 8'h80, 1'b0);
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    check("t4_busy",  32'(bus.busy),      32'd0);
    check("t4_ready", 32'(bus.in_ready),  32'd1);
    check("t4_valid", 32'(bus.out_valid), 32'd0);
    check("t4_sum",   32'(bus.sum),       32'd0);
    seen = 1'b0;
    for (int i = 0; i < N + 4; i++) begin
      seen = seen | bus.out_valid;
      @(negedge clk);
    end
    check("t4_no_valid", 32'(seen), 32'd0);
    issue("t4b", 8'h80, 8'h80, 1'b0);
    wait_done(lat);
    check("t4b_result", dut_result(), ref_add(8'h80, 8'h80, 1'b0));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // 5: operand and in_valid churn during RUN must not disturb the result
    issue("t5", 8'h0F, 8'hF0, 1'b1);
    lat = 0;
    while (!bus.out_valid && lat < 4 * N + 8) begin
      bus.a        = N'($urandom);
      bus.b        = N'($urandom);
      bus.ci       = 1'($urandom);
      bus.in_valid = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    check("t5_latency", 32'(lat), 32'(N));
    check("t5_result", dut_result(), ref_add(8'h0F, 8'hF0, 1'b1));
    bus.out_ready = 1'b1;
    @(negedge clk);

    // 6: back-to-back random traffic, results and issue spacing against a queue
    begin
      logic [31:0] expq[$];
      int          n_acc;
      int          n_res;
      int          cyc;
      int          last_acc;
      n_acc    = 0;
      n_res    = 0;
      cyc      = 0;
      last_acc = -1;
      bus.out_ready = 1'b1;
      while (n_res < 100 && cyc < 3000) begin
        if (bus.out_valid) begin
          if (expq.size() == 0) begin
            check("t6_unexpected", 32'd1, 32'd0);
          end else begin
            check("t6_result", dut_result(), expq.pop_front());
          end
          n_res++;
        end
        ra = N'($urandom);
        rb = N'($urandom);
        rc = 1'($urandom);
        bus.a  = ra;
        bus.b  = rb;
        bus.ci = rc;
        bus.in_valid = (n_acc < 100);
        if (bus.in_ready && bus.in_valid) begin
          expq.push_back(ref_add(ra, rb, rc));
          if (last_acc >= 0) begin
            check("t6_spacing", 32'(cyc - last_acc), 32'(N + 2));
          end
          last_acc = cyc;
          n_acc++;
        end
        @(negedge clk);
        cyc++;
      end
      check("t6_count", 32'(n_res), 32'd100);
      bus.in_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
